potential_decay_array: RTL and testbench
========================================

# potential_decay_array

Time-multiplexed leak stage for a bank of `NUM_NEURONS` LIF neurons holding IEEE-754 single-precision membrane potentials. Each neuron has its own decay-rate code. On a timestep strobe the block sweeps every neuron once, one per clock, and writes the decayed value back in place. The decayed stream is also exported for the spike/threshold stage. It sits between the potential adder, which overwrites potentials through the accumulate port, and the threshold comparator.

## Interface
- `NUM_NEURONS`, 32: neurons held; must be ≥2.
- `ADDR_W`, 5: address width; must satisfy 2^ADDR_W ≥ NUM_NEURONS.
- `clk` input 1: the single clock; every register updates on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `cfg_we` input 1: configuration write strobe.
- `cfg_addr` input ADDR_W: neuron to configure.
- `cfg_potential` input 32: initial potential (FP32).
- `cfg_rate` input 3: decay code for the neuron.
- `acc_we` input 1: potential-adder write strobe.
- `acc_addr` input ADDR_W: neuron to overwrite.
- `acc_data` input 32: new potential (FP32).
- `step_start` input 1: timestep strobe.
- `busy` output 1: sweep in progress.
- `step_done` output 1: one-cycle pulse on the last neuron of a sweep.
- `dec_valid` output 1: decayed-sample strobe.
- `dec_addr` output ADDR_W: neuron index of the sample.
- `dec_data` output 32: decayed potential.
- `rd_addr` input ADDR_W: debug read address.
- `rd_data` output 32: debug read data, one-cycle latency.
- `wr_drop` output 1: sticky flag; a write was dropped during a sweep.

## Operation
- Storage: register array `pot[NUM_NEURONS]` (32b) and `rate[NUM_NEURONS]` (3b).
- Write rules:
  - `cfg_we` writes both `pot` and `rate`; `acc_we` writes `pot` only.
  - When both strobes target the same address in the same cycle, `cfg_we` wins.
  - Addresses ≥ NUM_NEURONS are ignored.
- Writes during a sweep: if `busy`=1, `cfg_we` and `acc_we` are dropped and `wr_drop` is set. `wr_drop` clears only on reset.
- State machine:
  - IDLE to SWEEP when `step_start`=1 (and `busy`=0); index `idx` is set to 0.
  - SWEEP processes `pot[idx]` each cycle, then increments `idx`.
  - SWEEP to IDLE after `idx`=NUM_NEURONS-1.
  - `step_start` while in SWEEP is ignored.
- Decay of input x = {s, e, m}:
  - Rate codes:
    - 0: x (no decay)
    - 1: x/2
    - 2: x/4
    - 3: x/8
    - 4: 0.75x
    - 5: x/16
    - 6: +0.0 (hard reset)
    - 7: x (treated as code 0)
  - Shift codes 1, 2, 3, 5 (k = 1, 2, 3, 4): if e > k, the result is {s, e−k, m}. Otherwise the result is signed zero {s, 31'b0}; denormals are flushed.
  - Code 4:
    - sig = {1, m} (24b); p = sig + (sig<<1) (26b).
    - If p[25]=1, result = {s, e, p[24:2]}.
    - Else result = {s, e−1, p[23:1]}; if e ≤ 1 in this branch, result is signed zero.
    - Rounding is by truncation.
  - Special inputs:
    - e=0 (zero or denormal) gives signed zero for every code except 6.
    - e=255 (Inf/NaN) passes through unchanged for every code except 6.
- Writeback: the decayed value is written to `pot[idx]` on the same edge that registers the `dec_*` outputs.

## Timing
- Reset values:
  - Outputs: `busy`, `step_done`, `dec_valid`, `wr_drop` = 0; `dec_addr`, `dec_data`, `rd_data` = 0.
  - Storage: all `pot` and `rate` entries = 0; FSM in IDLE.
- Reset asserted mid-sweep aborts the sweep: no `step_done`, and all state is cleared on that edge.
- Sweep timing (`step_start` sampled at edge T0):
  - `busy`=1 from T0 through edge T0+NUM_NEURONS−1 inclusive.
  - Neuron i is decayed and written at edge T0+1+i, with `dec_valid`=1, `dec_addr`=i, `dec_data`=result for that cycle.
  - `step_done` coincides with the sample for i = NUM_NEURONS−1.
  - `busy`=0 after that edge, so `step_start` is accepted again in the cycle after `step_done`.
- Total sweep latency is NUM_NEURONS+1 edges from `step_start` to the final writeback.
- A write accepted at the same edge as `step_start` completes before neuron 0 is read.
- `rd_data` at edge t+1 is `pot[rd_addr]` as it was before any write at edge t+1; an out-of-range `rd_addr` reads 0.

## Test plan
- Reset, then `cfg` n0 = 0x41DED852 with rate 1, then `step_start`: `dec_data`=0x415ED852 at `dec_addr`=0; `rd_data` of n0 then reads 0x415ED852.
- Rate 4 on 0x41DED852 gives 0x41A7223D. Rate 5 on 0x41DED852 gives 0x3FDED852. Rate 3 on 0xC1DED852 gives 0xC05ED852.
- Underflow and specials:
  - Rate 1 on 0x00800000 gives 0x00000000.
  - Rate 3 on 0x80800000 gives 0x80000000.
  - 0x7F800000 (Inf) is unchanged under rate 2.
  - Rate 6 on any value gives 0x00000000.
- Sweep framing with NUM_NEURONS=32:
  - `dec_addr` runs 0..31 on consecutive cycles; `step_done` is high only at addr 31.
  - `busy` spans exactly 32 cycles.
  - A second `step_start` pulsed mid-sweep produces no extra samples.
- Write rules:
  - `acc_we` during a sweep: `pot` is unchanged and `wr_drop`=1 until reset.
  - Same-cycle `cfg_we`/`acc_we` to n3 while idle: the `cfg` value is stored.
- Reset at the 10th sweep cycle: `busy`, `dec_valid` = 0 the next cycle, no `step_done` occurs, and all `pot` entries read 0.

Source files
------------

// File: rtl/potential_decay_array_if.sv
// Bus bundle for the leak stage: configuration and accumulate writes,
// sweep control, decayed-sample stream and debug read port.
interface potential_decay_array_if #(
   parameter int ADDR_W = 5
);
   logic              cfg_we;
   logic [ADDR_W-1:0] cfg_addr;
   logic [31:0]       cfg_potential;
   logic [2:0]        cfg_rate;
   logic              acc_we;
   logic [ADDR_W-1:0] acc_addr;
   logic [31:0]       acc_data;
   logic              step_start;
   logic              busy;
   logic              step_done;
   logic              dec_valid;
   logic [ADDR_W-1:0] dec_addr;
   logic [31:0]       dec_data;
   logic [ADDR_W-1:0] rd_addr;
   logic [31:0]       rd_data;
   logic              wr_drop;

   modport master (
      output cfg_we, cfg_addr, cfg_potential, cfg_rate,
      output acc_we, acc_addr, acc_data,
      output step_start, rd_addr,
      input  busy, step_done, dec_valid, dec_addr, dec_data,
      input  rd_data, wr_drop
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_potential, cfg_rate,
      input  acc_we, acc_addr, acc_data,
      input  step_start, rd_addr,
      output busy, step_done, dec_valid, dec_addr, dec_data,
      output rd_data, wr_drop
   );
endinterface

// File: rtl/potential_decay_array.sv
// Time-multiplexed FP32 leak stage: one neuron per clock is decayed by
// its own rate code and written back in place, with the result exported.
module potential_decay_array #(
   parameter int NUM_NEURONS = 32,
   parameter int ADDR_W      = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   potential_decay_array_if.slave bus
);

   typedef enum logic {
      ST_IDLE,
      ST_SWEEP
   } state_t;

   localparam logic [ADDR_W:0]   NUM_L = (ADDR_W+1)'(NUM_NEURONS);
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_NEURONS - 1);

   state_t            state_q;
   logic [ADDR_W-1:0] idx_q;
   logic [31:0]       pot_q  [NUM_NEURONS];
   logic [2:0]        rate_q [NUM_NEURONS];
   logic              busy_q;
   logic              done_q;
   logic              dv_q;
   logic [ADDR_W-1:0] daddr_q;
   logic [31:0]       ddata_q;
   logic [31:0]       rd_q;
   logic              drop_q;

   logic              cfg_ok;
   logic              acc_ok;
   logic              rd_ok;
   logic [31:0]       dec_d;
   logic [ADDR_W-1:0] idx_d;

   // Truncating decay; zero/denormal flush to signed zero, Inf/NaN pass.
   function automatic logic [31:0] decay(
      input logic [31:0] x,
      input logic [2:0]  code
   );
      logic        s;
      logic [7:0]  e;
      logic [22:0] m;
      logic [23:0] sig;
      logic [25:0] p;
      logic [7:0]  k;
      logic [31:0] z;
      logic [31:0] r;
      s   = x[31];
      e   = x[30:23];
      m   = x[22:0];
      z   = {s, 31'b0};
      sig = {1'b1, m};
      p   = {2'b00, sig} + {1'b0, sig, 1'b0};
      unique case (code)
         3'd1:    k = 8'd1;
         3'd2:    k = 8'd2;
         3'd3:    k = 8'd3;
         3'd5:    k = 8'd4;
         default: k = 8'd0;
      endcase
      if (code == 3'd6) begin
         r = '0;
      end else if (e == 8'd0) begin
         r = z;
      end else if (e == 8'hFF) begin
         r = x;
      end else if (code == 3'd4) begin
         if (p[25])
            r = {s, e, p[24:2]};
         else if (e <= 8'd1)
            r = z;
         else
            r = {s, e - 8'd1, p[23:1]};
      end else if (k == 8'd0) begin
         r = x;
      end else if (e > k) begin
         r = {s, e - k, m};
      end else begin
         r = z;
      end
      return r;
   endfunction

   assign cfg_ok = bus.cfg_we && ({1'b0, bus.cfg_addr} < NUM_L);
   assign acc_ok = bus.acc_we && ({1'b0, bus.acc_addr} < NUM_L);
   assign rd_ok  = {1'b0, bus.rd_addr} < NUM_L;
   assign dec_d  = decay(pot_q[idx_q], rate_q[idx_q]);
   assign idx_d  = idx_q + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dv_q    <= 1'b0;
         daddr_q <= '0;
         ddata_q <= '0;
         rd_q    <= '0;
         drop_q  <= 1'b0;
         for (int i = 0; i < NUM_NEURONS; i++) begin
            pot_q[i]  <= '0;
            rate_q[i] <= '0;
         end
      end else begin
         dv_q   <= 1'b0;
         done_q <= 1'b0;
         rd_q   <= rd_ok ? pot_q[bus.rd_addr] : '0;
         unique case (state_q)
            ST_IDLE: begin
               // cfg is applied last so it wins an address collision
               if (acc_ok)
                  pot_q[bus.acc_addr] <= bus.acc_data;
               if (cfg_ok) begin
                  pot_q[bus.cfg_addr]  <= bus.cfg_potential;
                  rate_q[bus.cfg_addr] <= bus.cfg_rate;
               end
               if (bus.step_start) begin
                  state_q <= ST_SWEEP;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            ST_SWEEP: begin
               if (bus.cfg_we || bus.acc_we)
                  drop_q <= 1'b1;
               pot_q[idx_q] <= dec_d;
               dv_q         <= 1'b1;
               daddr_q      <= idx_q;
               ddata_q      <= dec_d;
               if (idx_q == LAST) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  idx_q <= idx_d;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.step_done = done_q;
   assign bus.dec_valid = dv_q;
   assign bus.dec_addr  = daddr_q;
   assign bus.dec_data  = ddata_q;
   assign bus.rd_data   = rd_q;
   assign bus.wr_drop   = drop_q;

endmodule

// File: tb/tb_potential_decay_array.sv
// Randomized bench for potential_decay_array against a value-level
// reference model, plus directed literal checks.
module tb_potential_decay_array;

   localparam int N  = 32;
   localparam int AW = 5;

   localparam logic [31:0] DIR_POT [8] = '{
      32'h41DED852, 32'h41DED852, 32'h41DED852, 32'hC1DED852,
      32'h00800000, 32'h80800000, 32'h7F800000, 32'h3F800000
   };
   localparam logic [2:0] DIR_RATE [8] = '{
      3'd1, 3'd4, 3'd5, 3'd3, 3'd1, 3'd3, 3'd2, 3'd6
   };
   localparam logic [31:0] DIR_EXP [8] = '{
      32'h415ED852, 32'h41A7223D, 32'h3FDED852, 32'hC05ED852,
      32'h00000000, 32'h80000000, 32'h7F800000, 32'h00000000
   };

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   potential_decay_array_if #(.ADDR_W(AW)) bus ();

   potential_decay_array #(
      .NUM_NEURONS(N),
      .ADDR_W     (AW)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Value-level decay: scale the significand by num/2^sh, renormalise.
   function automatic logic [31:0] ref_decay(input logic [31:0] x,
                                             input int code);
      int          e;
      int          num;
      int          sh;
      int          pos;
      int          ne;
      logic [47:0] prod;
      logic [47:0] mant;
      e = int'(x[30:23]);
      if (code == 6) return 32'h0;
      if (e == 0) return {x[31], 31'b0};
      if (e == 255) return x;
      num = 1;
      sh  = 0;
      case (code)
         1: sh = 1;
         2: sh = 2;
         3: sh = 3;
         4: begin num = 3; sh = 2; end
         5: sh = 4;
         default: sh = 0;
      endcase
      prod = 48'({1'b1, x[22:0]}) * 48'(num);
      pos = 0;
      for (int b = 0; b < 48; b++)
         if (prod[b]) pos = b;
      ne   = e - sh + (pos - 23);
      mant = prod >> (pos - 23);
      if (ne <= 0) return {x[31], 31'b0};
      return {x[31], 8'(ne), mant[22:0]};
   endfunction

   logic [31:0]   pot_m  [N];
   logic [2:0]    rate_m [N];
   int            spos = -1;
   bit            armed = 1'b0;
   logic          e_busy, e_done, e_dv, e_drop;
   logic [AW-1:0] e_addr;
   logic [31:0]   e_data, e_rd, mr;

   always @(posedge clk) begin
      armed = 1'b1;
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            pot_m[i]  = '0;
            rate_m[i] = '0;
         end
         spos   = -1;
         e_busy = 0; e_done = 0; e_dv = 0; e_drop = 0;
         e_addr = '0; e_data = '0; e_rd = '0;
      end else begin
         e_rd   = pot_m[bus.rd_addr];
         e_dv   = 0;
         e_done = 0;
         if (spos >= 0) begin
            if (bus.cfg_we || bus.acc_we) e_drop = 1;
            mr          = ref_decay(pot_m[spos], int'(rate_m[spos]));
            pot_m[spos] = mr;
            e_dv        = 1;
            e_addr      = AW'(spos);
            e_data      = mr;
            if (spos == N - 1) begin
               e_done = 1;
               spos   = -1;
            end else begin
               spos++;
            end
         end else begin
            if (bus.acc_we) pot_m[bus.acc_addr] = bus.acc_data;
            if (bus.cfg_we) begin
               pot_m[bus.cfg_addr]  = bus.cfg_potential;
               rate_m[bus.cfg_addr] = bus.cfg_rate;
            end
            if (bus.step_start) spos = 0;
         end
         e_busy = (spos >= 0);
      end
   end

   logic [31:0]   got [N];
   int            dv_cnt = 0, done_cnt = 0, busy_cnt = 0;
   logic [AW-1:0] done_addr = '0;

   always @(negedge clk) begin
      if (armed) begin
         check("busy",      32'(bus.busy),      32'(e_busy));
         check("step_done", 32'(bus.step_done), 32'(e_done));
         check("dec_valid", 32'(bus.dec_valid), 32'(e_dv));
         check("dec_addr",  32'(bus.dec_addr),  32'(e_addr));
         check("dec_data",  bus.dec_data,       e_data);
         check("rd_data",   bus.rd_data,        e_rd);
         check("wr_drop",   32'(bus.wr_drop),   32'(e_drop));
         if (bus.dec_valid) begin
            got[bus.dec_addr] = bus.dec_data;
            dv_cnt++;
         end
         if (bus.step_done) begin
            done_cnt++;
            done_addr = bus.dec_addr;
         end
         if (bus.busy) busy_cnt++;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic quiet();
      bus.cfg_we     = 0;
      bus.acc_we     = 0;
      bus.step_start = 0;
   endtask

   task automatic clr_cnt();
      dv_cnt   = 0;
      done_cnt = 0;
      busy_cnt = 0;
   endtask

   function automatic logic [31:0] rnd_pot();
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 3))
         0:       v[30:23] = 8'($urandom_range(0, 5));
         1:       v[30:23] = 8'($urandom_range(250, 255));
         default: ;
      endcase
      return v;
   endfunction

   initial begin
      bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_potential = '0;
      bus.cfg_rate = '0; bus.acc_we = 0; bus.acc_addr = '0;
      bus.acc_data = '0; bus.step_start = 0; bus.rd_addr = '0;
      repeat (3) tick();
      check("rst busy",    32'(bus.busy),    32'd0);
      check("rst dec_data", bus.dec_data,    32'd0);
      check("rst rd_data", bus.rd_data,      32'd0);
      check("rst wr_drop", 32'(bus.wr_drop), 32'd0);
      rst_n = 1;
      tick();

      // collision: cfg beats acc on n3
      bus.cfg_we = 1; bus.cfg_addr = 5'd3;
      bus.cfg_potential = 32'hC1DED852; bus.cfg_rate = 3'd3;
      bus.acc_we = 1; bus.acc_addr = 5'd3; bus.acc_data = 32'h12345678;
      tick();
      quiet();
      bus.rd_addr = 5'd3;
      tick();
      check("collision n3", bus.rd_data, 32'hC1DED852);

      for (int i = 0; i < N; i++) begin
         bus.cfg_we   = 1;
         bus.cfg_addr = AW'(i);
         if (i < 8) begin
            bus.cfg_potential = DIR_POT[i];
            bus.cfg_rate      = DIR_RATE[i];
         end else begin
            bus.cfg_potential = rnd_pot();
            bus.cfg_rate      = 3'($urandom_range(0, 7));
         end
         tick();
      end
      quiet();
      tick();

      // directed sweep with an ignored mid-sweep start
      clr_cnt();
      bus.step_start = 1;
      tick();
      bus.step_start = 0;
      repeat (10) tick();
      bus.step_start = 1;
      tick();
      bus.step_start = 0;
      repeat (N) tick();
      check("sample count", 32'(dv_cnt),    32'd32);
      check("done count",   32'(done_cnt),  32'd1);
      check("done addr",    32'(done_addr), 32'd31);
      check("busy span",    32'(busy_cnt),  32'd32);
      for (int i = 0; i < 8; i++)
         check($sformatf("decay n%0d", i), got[i], DIR_EXP[i]);
      bus.rd_addr = 5'd0;
      tick();
      check("readback n0", bus.rd_data, 32'h415ED852);

      // acc write during sweep is dropped
      bus.step_start = 1;
      tick();
      bus.step_start = 0;
      repeat (5) tick();
      bus.acc_we = 1; bus.acc_addr = 5'd5; bus.acc_data = 32'h3F800000;
      tick();
      bus.acc_we = 0;
      repeat (N) tick();
      check("wr_drop set", 32'(bus.wr_drop), 32'd1);
      bus.rd_addr = 5'd5;
      tick();
      check("n5 kept", bus.rd_data, 32'h80000000);

      for (int c = 0; c < 2500; c++) begin
         bus.cfg_we        = ($urandom_range(0, 4) == 0);
         bus.cfg_addr      = AW'($urandom);
         bus.cfg_potential = rnd_pot();
         bus.cfg_rate      = 3'($urandom);
         bus.acc_we        = ($urandom_range(0, 4) == 0);
         bus.acc_addr      = (bus.cfg_we && $urandom_range(0, 3) == 0)
                             ? bus.cfg_addr : AW'($urandom);
         bus.acc_data      = rnd_pot();
         bus.step_start    = ($urandom_range(0, 19) == 0);
         bus.rd_addr       = AW'($urandom);
         tick();
      end
      quiet();
      repeat (N + 2) tick();

      // reset on the 10th sweep cycle
      clr_cnt();
      bus.step_start = 1;
      tick();
      bus.step_start = 0;
      repeat (9) tick();
      rst_n = 0;
      tick();
      check("abort busy", 32'(bus.busy),      32'd0);
      check("abort dv",   32'(bus.dec_valid), 32'd0);
      rst_n = 1;
      repeat (N + 2) tick();
      check("abort no done", 32'(done_cnt), 32'd0);
      for (int i = 0; i < N; i++) begin
         bus.rd_addr = AW'(i);
         tick();
         check($sformatf("cleared n%0d", i), bus.rd_data, 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
